// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared light encodings, fault codes and monitor state type
//               for the traffic conflict monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    // One-hot light encoding, bit order [Left, Green, Yellow, Red]
    localparam logic [3:0] LEFT_GREEN     = 4'b1000;
    localparam logic [3:0] STRAIGHT_GREEN = 4'b0100;
    localparam logic [3:0] YELLOW         = 4'b0010;
    localparam logic [3:0] RED            = 4'b0001;

    // Fault codes; lower value wins when several are active together
    localparam logic [2:0] FC_NONE         = 3'd0;
    localparam logic [2:0] FC_ENCODING     = 3'd1;
    localparam logic [2:0] FC_CONFLICT     = 3'd2;
    localparam logic [2:0] FC_NO_YELLOW    = 3'd3;
    localparam logic [2:0] FC_SHORT_YELLOW = 3'd4;
    localparam logic [2:0] FC_STUCK        = 3'd5;

    typedef enum logic [1:0] {
        STARTUP = 2'd0,
        NORMAL  = 2'd1,
        FAULT   = 2'd2
    } mon_state_t;

    // True when exactly one bit of a light vector is set
    function automatic logic is_onehot(input logic [3:0] v);
        return (v == LEFT_GREEN) || (v == STRAIGHT_GREEN) ||
               (v == YELLOW)     || (v == RED);
    endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_conflict_monitor_tl_dir_checker.sv
`default_nettype none
// ============================================================================
// Module      : tl_dir_checker
// Description : Per-direction tracker. Holds the previous light sample and
//               the consecutive-yellow count, and flags bad encodings,
//               green-to-red jumps and yellows that were too short.
// Revision    : 1.0 - initial release
// ============================================================================
module tl_dir_checker
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] light,
    output logic [3:0] prev_light,
    output logic       enc_err,
    output logic       no_yellow,
    output logic       short_yellow
);

    localparam int YW = (MIN_YELLOW > 1) ? $clog2(MIN_YELLOW + 1) : 1;
    localparam logic [YW-1:0] C_YEL_SAT = YW'(MIN_YELLOW);

    logic [3:0]    r_prev;
    logic [YW-1:0] r_yel_cnt;

    // Track the last sample and a saturating run length of yellow samples
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev    <= RED;
            r_yel_cnt <= '0;
        end else begin
            r_prev <= light;
            if (light != YELLOW) begin
                r_yel_cnt <= '0;
            end else if (r_yel_cnt != C_YEL_SAT) begin
                r_yel_cnt <= r_yel_cnt + 1'b1;
            end
        end
    end

    assign prev_light   = r_prev;
    assign enc_err      = !is_onehot(light);
    assign no_yellow    = ((r_prev == LEFT_GREEN) || (r_prev == STRAIGHT_GREEN)) &&
                          (light == RED);
    assign short_yellow = (r_prev == YELLOW) && (light == RED) &&
                          (r_yel_cnt < C_YEL_SAT);

endmodule
`default_nettype wire

// File: rtl/traffic_conflict_monitor.sv
`default_nettype none
// ============================================================================
// Module      : traffic_conflict_monitor
// Description : Safety stage between the intersection controller and the
//               lamp drivers. Registers the four light vectors onto the lamps,
//               and on any illegal pattern latches a fault code and switches
//               the lamps to an all-red flash until the operator clears it.
//               Optional macro MONITOR_EVENT_CNT_EN adds an 8-bit saturating
//               fault_count output counting NORMAL-to-FAULT entries.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_conflict_monitor
    import traffic_pkg::*;
#(
    parameter int STARTUP_CYCLES  = 4,
    parameter int MIN_YELLOW      = 2,
    parameter int WATCHDOG_CYCLES = 64,
    parameter int FLASH_HALF      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] north_tl,
    input  logic [3:0] south_tl,
    input  logic [3:0] east_tl,
    input  logic [3:0] west_tl,
    input  logic       fault_clear,
    output logic [3:0] north_lamp,
    output logic [3:0] south_lamp,
    output logic [3:0] east_lamp,
    output logic [3:0] west_lamp,
    output logic       fault,
    output logic [2:0] fault_code,
`ifdef MONITOR_EVENT_CNT_EN
    output logic [7:0] fault_count,
`endif
    output logic       mon_ok
);

    localparam int SCW = (STARTUP_CYCLES > 1)  ? $clog2(STARTUP_CYCLES + 1)  : 1;
    localparam int WDW = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES + 1) : 1;
    localparam int FLW = (FLASH_HALF > 1)      ? $clog2(FLASH_HALF + 1)      : 1;

    localparam logic [SCW-1:0] C_START_LAST = SCW'(STARTUP_CYCLES - 1);
    localparam logic [WDW-1:0] C_WD_LAST    = WDW'(WATCHDOG_CYCLES - 1);
    localparam logic [WDW-1:0] C_WD_SAT     = WDW'(WATCHDOG_CYCLES);
    localparam logic [FLW-1:0] C_FLASH_LAST = FLW'(FLASH_HALF - 1);

    logic [3:0] w_in   [4];
    logic [3:0] w_prev [4];
    logic [3:0] w_enc;
    logic [3:0] w_noy;
    logic [3:0] w_shy;
    logic       w_conflict;
    logic       w_same;
    logic       w_stuck;
    logic [2:0] w_code;
    logic       w_violation;

    mon_state_t r_state;
    mon_state_t w_next;

    logic [3:0]     r_lamp [4];
    logic           r_fault;
    logic [2:0]     r_fault_code;
    logic           r_mon_ok;
    logic [SCW-1:0] r_start_cnt;
    logic [WDW-1:0] r_wd_cnt;
    logic [FLW-1:0] r_flash_cnt;
    logic           r_flash_on;

    assign w_in[0] = north_tl;
    assign w_in[1] = south_tl;
    assign w_in[2] = east_tl;
    assign w_in[3] = west_tl;

    generate
        for (genvar g = 0; g < 4; g++) begin : g_dir
            tl_dir_checker #(
                .MIN_YELLOW   (MIN_YELLOW)
            ) u_chk (
                .clk          (clk),
                .reset        (reset),
                .light        (w_in[g]),
                .prev_light   (w_prev[g]),
                .enc_err      (w_enc[g]),
                .no_yellow    (w_noy[g]),
                .short_yellow (w_shy[g])
            );
        end
    endgenerate

    assign w_conflict = ((north_tl != RED) || (south_tl != RED)) &&
                        ((east_tl  != RED) || (west_tl  != RED));
    assign w_same     = (w_in[0] == w_prev[0]) && (w_in[1] == w_prev[1]) &&
                        (w_in[2] == w_prev[2]) && (w_in[3] == w_prev[3]);
    // This edge would be the WATCHDOG_CYCLES-th unchanged sample in a row
    assign w_stuck    = w_same && (r_wd_cnt >= C_WD_LAST);

    // Lowest-numbered active fault code
    always_comb begin
        w_code = FC_NONE;
        if (|w_enc) begin
            w_code = FC_ENCODING;
        end else if (w_conflict) begin
            w_code = FC_CONFLICT;
        end else if (|w_noy) begin
            w_code = FC_NO_YELLOW;
        end else if (|w_shy) begin
            w_code = FC_SHORT_YELLOW;
        end else if (w_stuck) begin
            w_code = FC_STUCK;
        end
    end

    assign w_violation = (w_code != FC_NONE);

    // Monitor state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= STARTUP;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection
    always_comb begin
        w_next = r_state;
        case (r_state)
            STARTUP: if (r_start_cnt == C_START_LAST) w_next = NORMAL;
            NORMAL:  if (w_violation)                 w_next = FAULT;
            FAULT:   if (fault_clear)                 w_next = STARTUP;
            default:                                  w_next = STARTUP;
        endcase
    end

    // Lamp drive, fault latch, watchdog and flash timing
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) r_lamp[i] <= RED;
            r_fault      <= 1'b0;
            r_fault_code <= FC_NONE;
            r_mon_ok     <= 1'b0;
            r_start_cnt  <= '0;
            r_wd_cnt     <= '0;
            r_flash_cnt  <= '0;
            r_flash_on   <= 1'b1;
        end else begin
            case (r_state)
                STARTUP: begin
                    for (int i = 0; i < 4; i++) r_lamp[i] <= RED;
                    r_mon_ok    <= 1'b0;
                    r_wd_cnt    <= '0;
                    r_start_cnt <= (r_start_cnt == C_START_LAST) ? '0 : r_start_cnt + 1'b1;
                end
                NORMAL: begin
                    if (w_violation) begin
                        // Offending pattern is replaced by flash-on red at this edge
                        for (int i = 0; i < 4; i++) r_lamp[i] <= RED;
                        r_fault      <= 1'b1;
                        r_fault_code <= w_code;
                        r_mon_ok     <= 1'b0;
                        r_flash_cnt  <= '0;
                        r_flash_on   <= 1'b1;
                    end else begin
                        for (int i = 0; i < 4; i++) r_lamp[i] <= w_in[i];
                        r_mon_ok <= 1'b1;
                        if (!w_same) begin
                            r_wd_cnt <= '0;
                        end else if (r_wd_cnt != C_WD_SAT) begin
                            r_wd_cnt <= r_wd_cnt + 1'b1;
                        end
                    end
                end
                FAULT: begin
                    r_mon_ok <= 1'b0;
                    if (fault_clear) begin
                        for (int i = 0; i < 4; i++) r_lamp[i] <= RED;
                        r_fault      <= 1'b0;
                        r_fault_code <= FC_NONE;
                        r_start_cnt  <= '0;
                    end else if (r_flash_cnt == C_FLASH_LAST) begin
                        r_flash_cnt <= '0;
                        r_flash_on  <= !r_flash_on;
                        for (int i = 0; i < 4; i++) r_lamp[i] <= {3'b000, !r_flash_on};
                    end else begin
                        r_flash_cnt <= r_flash_cnt + 1'b1;
                        for (int i = 0; i < 4; i++) r_lamp[i] <= {3'b000, r_flash_on};
                    end
                end
                default: begin
                    for (int i = 0; i < 4; i++) r_lamp[i] <= RED;
                    r_mon_ok <= 1'b0;
                end
            endcase
        end
    end

`ifdef MONITOR_EVENT_CNT_EN
    logic [7:0] r_fault_count;

    // Saturating count of NORMAL-to-FAULT entries; only reset clears it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault_count <= 8'd0;
        end else if ((r_state == NORMAL) && w_violation && (r_fault_count != 8'hFF)) begin
            r_fault_count <= r_fault_count + 8'd1;
        end
    end

    assign fault_count = r_fault_count;
`endif

    assign north_lamp = r_lamp[0];
    assign south_lamp = r_lamp[1];
    assign east_lamp  = r_lamp[2];
    assign west_lamp  = r_lamp[3];
    assign fault      = r_fault;
    assign fault_code = r_fault_code;
    assign mon_ok     = r_mon_ok;

endmodule
`default_nettype wire

// File: tb/tb_traffic_conflict_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_conflict_monitor
// Description : Scoreboard bench for traffic_conflict_monitor. A reference
//               model predicts every cycle's outputs; a monitor compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_conflict_monitor;

    localparam int STARTUP_CYCLES  = 4;
    localparam int MIN_YELLOW      = 2;
    localparam int WATCHDOG_CYCLES = 64;
    localparam int FLASH_HALF      = 4;

    localparam logic [3:0] L = 4'b1000;
    localparam logic [3:0] G = 4'b0100;
    localparam logic [3:0] Y = 4'b0010;
    localparam logic [3:0] R = 4'b0001;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] north_tl, south_tl, east_tl, west_tl;
    logic       fault_clear;
    logic [3:0] north_lamp, south_lamp, east_lamp, west_lamp;
    logic       fault;
    logic [2:0] fault_code;
    logic       mon_ok;
`ifdef MONITOR_EVENT_CNT_EN
    logic [7:0] fault_count;
`endif

    always #5 clk = ~clk;

    traffic_conflict_monitor #(
        .STARTUP_CYCLES  (STARTUP_CYCLES),
        .MIN_YELLOW      (MIN_YELLOW),
        .WATCHDOG_CYCLES (WATCHDOG_CYCLES),
        .FLASH_HALF      (FLASH_HALF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .north_tl    (north_tl),
        .south_tl    (south_tl),
        .east_tl     (east_tl),
        .west_tl     (west_tl),
        .fault_clear (fault_clear),
        .north_lamp  (north_lamp),
        .south_lamp  (south_lamp),
        .east_lamp   (east_lamp),
        .west_lamp   (west_lamp),
        .fault       (fault),
        .fault_code  (fault_code),
`ifdef MONITOR_EVENT_CNT_EN
        .fault_count (fault_count),
`endif
        .mon_ok      (mon_ok)
    );

    typedef struct packed {
        logic [15:0] lamps;
        logic        fault;
        logic [2:0]  code;
        logic        mon_ok;
        logic [7:0]  cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: mode 0=startup 1=normal 2=fault
    int         m_mode = 0;
    int         m_start_seen = 0;
    int         m_same_run = 0;
    int         m_flash_age = 0;
    bit         m_lit = 1'b1;
    logic [3:0] m_prev [4];
    int         m_yel_run [4];
    exp_t       m_out;

    task automatic model_edge(input logic [3:0] in_v [4], input bit clr, input bit rst);
        bit enc, noy, shy, conf, same, stuck;
        int code;
        if (rst) begin
            m_mode = 0; m_start_seen = 0; m_same_run = 0; m_flash_age = 0; m_lit = 1'b1;
            for (int d = 0; d < 4; d++) begin m_prev[d] = R; m_yel_run[d] = 0; end
            m_out = '{lamps: {R, R, R, R}, fault: 1'b0, code: 3'd0, mon_ok: 1'b0, cnt: 8'd0};
            return;
        end
        enc = 0; noy = 0; shy = 0; same = 1;
        for (int d = 0; d < 4; d++) begin
            if ($countones(in_v[d]) != 1) enc = 1;
            if ((m_prev[d] == L || m_prev[d] == G) && in_v[d] == R) noy = 1;
            if (m_prev[d] == Y && in_v[d] == R && m_yel_run[d] < MIN_YELLOW) shy = 1;
            if (in_v[d] != m_prev[d]) same = 0;
        end
        conf  = (in_v[0] != R || in_v[1] != R) && (in_v[2] != R || in_v[3] != R);
        stuck = same && (m_same_run + 1 >= WATCHDOG_CYCLES);
        code  = enc ? 1 : conf ? 2 : noy ? 3 : shy ? 4 : stuck ? 5 : 0;
        case (m_mode)
            0: begin
                m_out.lamps = {R, R, R, R};
                m_out.mon_ok = 0;
                m_start_seen++;
                if (m_start_seen == STARTUP_CYCLES) begin
                    m_mode = 1; m_start_seen = 0; m_same_run = 0;
                end
            end
            1: begin
                if (code != 0) begin
                    m_mode = 2;
                    m_out.lamps = {R, R, R, R};
                    m_out.fault = 1;
                    m_out.code = 3'(code);
                    m_out.mon_ok = 0;
                    m_flash_age = 0; m_lit = 1;
                    if (m_out.cnt < 8'd255) m_out.cnt = m_out.cnt + 8'd1;
                end else begin
                    m_out.lamps = {in_v[0], in_v[1], in_v[2], in_v[3]};
                    m_out.mon_ok = 1;
                    m_same_run = same ? m_same_run + 1 : 0;
                end
            end
            default: begin
                m_out.mon_ok = 0;
                if (clr) begin
                    m_mode = 0; m_start_seen = 0;
                    m_out.lamps = {R, R, R, R};
                    m_out.fault = 0; m_out.code = 0;
                end else begin
                    m_flash_age++;
                    if (m_flash_age == FLASH_HALF) begin m_lit = !m_lit; m_flash_age = 0; end
                    m_out.lamps = m_lit ? {R, R, R, R} : 16'h0000;
                end
            end
        endcase
        for (int d = 0; d < 4; d++) begin
            m_yel_run[d] = (in_v[d] == Y) ? ((m_yel_run[d] < MIN_YELLOW) ? m_yel_run[d] + 1 : MIN_YELLOW) : 0;
            m_prev[d] = in_v[d];
        end
    endtask

    // Drive one cycle of stimulus and record the predicted response
    task automatic step(input logic [3:0] n, s, e, w, input bit clr, input bit rst);
        logic [3:0] v [4];
        @(negedge clk);
        north_tl = n; south_tl = s; east_tl = e; west_tl = w;
        fault_clear = clr; reset = rst;
        v[0] = n; v[1] = s; v[2] = e; v[3] = w;
        model_edge(v, clr, rst);
        q.push_back(m_out);
    endtask

    task automatic hold(input logic [3:0] n, s, e, w, input int k);
        for (int i = 0; i < k; i++) step(n, s, e, w, 1'b0, 1'b0);
    endtask

    task automatic restart(input logic [3:0] n, s, e, w);
        step(n, s, e, w, 1'b0, 1'b1);
        hold(n, s, e, w, STARTUP_CYCLES + 2);
    endtask

    // Monitor: every cycle the DUT presents a lamp frame; compare it
    always begin : monitor
        exp_t x;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            x = q.pop_front();
            checks++;
            if ({north_lamp, south_lamp, east_lamp, west_lamp} !== x.lamps) begin
                errors++;
                $display("FAIL lamps t=%0t got %h want %h", $time,
                         {north_lamp, south_lamp, east_lamp, west_lamp}, x.lamps);
            end
            checks++;
            if ({fault, fault_code} !== {x.fault, x.code}) begin
                errors++;
                $display("FAIL fault t=%0t got fault=%0b code=%0d want fault=%0b code=%0d",
                         $time, fault, fault_code, x.fault, x.code);
            end
            checks++;
            if (mon_ok !== x.mon_ok) begin
                errors++;
                $display("FAIL mon_ok t=%0t got %0b want %0b", $time, mon_ok, x.mon_ok);
            end
`ifdef MONITOR_EVENT_CNT_EN
            checks++;
            if (fault_count !== x.cnt) begin
                errors++;
                $display("FAIL fault_count t=%0t got %0d want %0d", $time, fault_count, x.cnt);
            end
`endif
        end
    end

    function automatic logic [3:0] rand_light();
        case ($urandom_range(0, 9))
            0, 1, 2, 3: return R;
            4:          return Y;
            5:          return G;
            6:          return L;
            default: begin
                if ($urandom_range(0, 3) == 0) return 4'($urandom_range(0, 15));
                return R;
            end
        endcase
    endfunction

    initial begin
        logic [3:0] rn, rs, re, rw;
        reset = 1'b1; fault_clear = 1'b0;
        north_tl = R; south_tl = R; east_tl = R; west_tl = R;

        // Startup hold, then pass-through
        restart(L, L, R, R);
        hold(L, L, R, R, 4);

        // Cross-axis conflict, flash pattern, offending pattern never shown
        step(L, L, G, R, 1'b0, 1'b0);
        hold(L, L, G, R, 2 * FLASH_HALF + 5);
        step(L, L, R, R, 1'b1, 1'b0);
        hold(L, L, R, R, STARTUP_CYCLES + 2);

        // Green straight to red: missing yellow
        restart(G, G, R, R);
        step(R, G, R, R, 1'b0, 1'b0);
        hold(R, G, R, R, 3);

        // One-cycle yellow: too short
        restart(G, G, R, R);
        step(Y, G, R, R, 1'b0, 1'b0);
        step(R, G, R, R, 1'b0, 1'b0);
        hold(R, G, R, R, 2);

        // Two-cycle yellow: legal
        restart(G, G, R, R);
        hold(Y, G, R, R, MIN_YELLOW);
        hold(R, G, R, R, 5);

        // Encoding and conflict at once: encoding wins
        restart(L, L, R, R);
        step(4'b0011, L, G, R, 1'b0, 1'b0);
        hold(R, R, R, R, 3);

        // Frozen controller, then operator clear
        restart(G, G, R, R);
        hold(G, G, R, R, WATCHDOG_CYCLES + 4);
        step(G, G, R, R, 1'b1, 1'b0);
        hold(G, R, R, R, STARTUP_CYCLES + 3);
        step(G, R, R, R, 1'b1, 1'b0);   // clear outside FAULT is ignored

        // Reset during the fault flash
        step(G, G, G, R, 1'b0, 1'b0);
        hold(G, G, G, R, 3);
        step(R, R, R, R, 1'b0, 1'b1);
        hold(R, R, R, R, 2);

        // Three fault/clear rounds
        restart(L, L, R, R);
        for (int k = 0; k < 3; k++) begin
            step(L, L, L, R, 1'b0, 1'b0);
            hold(L, L, L, R, 2);
            step(L, L, R, R, 1'b1, 1'b0);
            hold(L, L, R, R, STARTUP_CYCLES + 2);
        end

        // Randomised traffic with occasional clears and resets
        rn = R; rs = R; re = R; rw = R;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) < 3) begin
                rn = rand_light(); rs = rand_light(); re = rand_light(); rw = rand_light();
            end
            step(rn, rs, re, rw, ($urandom_range(0, 7) == 0), ($urandom_range(0, 299) == 0));
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
